ram_access_arbiter: RTL and testbench
=====================================

# ram_access_arbiter

Round-robin arbiter that shares one `ram_access` port between NREQ requesters. It serialises their single-word 32-bit read/write requests onto the `RW`/`ADDRESS`/`IN_DATA`/`OUT_DATA`/`ACK` port. It filters the stale and repeated ACKs that the free-running `ram_access` port produces, and returns each requester its own completion, read data and error status. It sits between the accelerator-side masters and `ram_access`, in the `ACLK` domain.

## Interface
- NREQ, 4: number of requesters, 2..8; IW = clog2(NREQ).
- TIMEOUT, 1024: maximum WAIT_ACK cycles before a fault is declared; 0 disables the timeout.
- ACLK  in  1  clock.
- ARESETn  in  1  reset, synchronous, active-high (despite the name).
- REQ  in  NREQ  per-requester request level.
- REQ_RW  in  NREQ  per-requester direction: 1 = write, 0 = read.
- REQ_ADDRESS  in  32*NREQ  word address; requester i uses bits [32i+31:32i].
- REQ_WDATA  in  32*NREQ  write data, same packing as REQ_ADDRESS.
- DONE  out  NREQ  one-cycle completion pulse to the granted requester.
- RDATA  out  32  read data, shared; valid only in a DONE cycle.
- ERR  out  1  shared; qualifies the DONE cycle as a timeout failure.
- GRANT_ID  out  IW  index of the current owner.
- BUSY  out  1  high in every state except IDLE.
- FAULT  out  1  sticky; set by a timeout, cleared only by reset.
- RW  out  1  to `ram_access` RW.
- ADDRESS  out  32  to `ram_access` ADDRESS.
- IN_DATA  out  32  to `ram_access` IN_DATA.
- OUT_DATA  in  32  from `ram_access`.
- ACK  in  1  from `ram_access`.

## Operation
- **Requester contract:**
  - A requester raises REQ[i] and holds REQ_RW/REQ_ADDRESS/REQ_WDATA stable until its DONE[i].
  - Dropping REQ before the grant withdraws the request.
  - Dropping REQ after the grant has no effect; the transfer completes.
- **Parked state:** `ram_access` has no valid strobe and re-executes whatever it sees.
  - Whenever the arbiter owns no transfer, it parks RW=0 and holds the last ADDRESS.
  - Parked reads are harmless. Their ACKs are never forwarded.
- **FSM states:** IDLE, GUARD, WAIT_ACK, DRAIN, FAULT.
- **IDLE:**
  - Choose the first i with REQ[i]=1, searching from pointer P upward with wrap.
  - Register GRANT_ID=i, RW=REQ_RW[i], ADDRESS=REQ_ADDRESS[i], IN_DATA=REQ_WDATA[i].
  - Set P=(i+1) mod NREQ, then go to GUARD.
  - If no REQ is high, stay in IDLE.
- **GUARD:** lasts exactly 2 cycles; ACK is ignored, because it belongs to the parked operation. Then go to WAIT_ACK with the timeout counter at 0.
- **WAIT_ACK, on ACK=1:**
  - Capture RDATA=OUT_DATA for a read; RDATA=0 for a write.
  - Pulse DONE[GRANT_ID] with ERR=0.
  - Park RW=0 and go to DRAIN.
- **WAIT_ACK, timeout:**
  - With TIMEOUT≠0, the counter increments every cycle while ACK=0.
  - When it reaches TIMEOUT, pulse DONE[GRANT_ID] with ERR=1 and RDATA=0.
  - Park RW=0, set FAULT=1 and go to FAULT.
- **DRAIN:** lasts exactly 2 cycles; ACK is ignored. This absorbs the idempotent repeat write issued while RW was still 1 in the ACK cycle. Then go to IDLE.
- **FAULT:** terminal. No grant is issued and REQ is ignored until reset, because `ram_access` may be mid-AXI.
- **Reset values:**
  - RW=0, ADDRESS=0, IN_DATA=0, DONE=0, RDATA=0, ERR=0.
  - GRANT_ID=0, BUSY=0, FAULT=0, P=0, state=IDLE.
- **Reset in any state:** returns to IDLE with no DONE pulse.

## Timing
- All outputs are registered.
- REQ is sampled in IDLE at cycle t:
  - New ADDRESS/RW/IN_DATA are visible at t+1.
  - GUARD covers t+1 and t+2.
  - WAIT_ACK starts at t+3.
- An ACK seen at cycle a produces DONE at a+1. DRAIN covers a+1 and a+2, and the next arbitration happens at a+3.
- On a cache hit, `ram_access` acks at t+3 at the earliest, giving DONE at t+4. Back-to-back transfers are then 6 cycles apart.
- ACK high in the same cycle that the counter reaches TIMEOUT counts as success.
- DONE is never asserted for more than one requester, and never for more than one cycle per transfer.

## Test plan
- Read hit: REQ[1], addr 0x10, with a model that acks 3 cycles after sampling and OUT_DATA=0xCAFEF00D → DONE[1] once, RDATA=0xCAFEF00D, ERR=0.
- Write then read: requester 0 writes 0x12345678 to 0x20, then reads 0x20 → second DONE returns 0x12345678; no extra DONE from the repeat write or from parked-read ACKs.
- Contention: REQ[0] and REQ[2] both rise in the same cycle after reset → grant order 0 then 2; GRANT_ID matches each DONE.
- Fairness: all 4 REQ held high → grants cycle 0,1,2,3,0; a requester that drops REQ before its grant is skipped.
- Timeout: TIMEOUT=8 with ACK tied low → DONE with ERR=1 exactly 8 WAIT_ACK cycles after entry; FAULT=1; later REQ ignored.
- Reset mid-WAIT_ACK and spurious ACK in GUARD: reset → all outputs return to reset values, next grant goes to requester 0; ACK pulses injected during GUARD/DRAIN → no DONE.

Source files
------------

// File: rtl/ram_access_arbiter_if.sv
// Requester and ram_access signal bundle for ram_access_arbiter.
// slave: arbiter side; master: requesters plus the ram_access port.
interface ram_access_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]      REQ;
    logic [NREQ-1:0]      REQ_RW;
    logic [32*NREQ-1:0]   REQ_ADDRESS;
    logic [32*NREQ-1:0]   REQ_WDATA;
    logic [NREQ-1:0]      DONE;
    logic [31:0]          RDATA;
    logic                 ERR;
    logic [IW-1:0]        GRANT_ID;
    logic                 BUSY;
    logic                 FAULT;
    logic                 RW;
    logic [31:0]          ADDRESS;
    logic [31:0]          IN_DATA;
    logic [31:0]          OUT_DATA;
    logic                 ACK;

    modport slave (
        input  REQ, REQ_RW, REQ_ADDRESS, REQ_WDATA, OUT_DATA, ACK,
        output DONE, RDATA, ERR, GRANT_ID, BUSY, FAULT,
        output RW, ADDRESS, IN_DATA
    );

    modport master (
        output REQ, REQ_RW, REQ_ADDRESS, REQ_WDATA, OUT_DATA, ACK,
        input  DONE, RDATA, ERR, GRANT_ID, BUSY, FAULT,
        input  RW, ADDRESS, IN_DATA
    );
endinterface

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter sharing one free-running ram_access port.
// Ports: ACLK, ARESETn (sync, active-high), bus (slave modport).
module ram_access_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024
) (
    input logic                 ACLK,
    input logic                 ARESETn,
    ram_access_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GUARD,
        S_WAIT_ACK,
        S_DRAIN,
        S_FAULT
    } state_t;

    state_t          state_q, state_d;
    logic            phase_q, phase_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            timeout_hit;

    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gid_q, gid_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            err_q, err_d;
    logic            busy_q;
    logic            fault_q, fault_d;
    logic            rw_q, rw_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;

    logic            found;
    logic [IW-1:0]   pick;
    logic [IW:0]     idx;
    logic [31:0]     sel_addr;
    logic [31:0]     sel_wdata;

    // First requester at or above the pointer, wrapping at NREQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr_q} + (IW+1)'(k);
            if (idx >= (IW+1)'(NREQ)) begin
                idx = idx - (IW+1)'(NREQ);
            end
            if (!found && bus.REQ[idx[IW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == IW'(i)) begin
                sel_addr  = bus.REQ_ADDRESS[32*i +: 32];
                sel_wdata = bus.REQ_WDATA[32*i +: 32];
            end
        end
    end

    // ACK in the same cycle as the limit still wins over the timeout.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));

    always_ff @(posedge ACLK) begin
        if (ARESETn) begin
            state_q <= S_IDLE;
            phase_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    // GUARD and DRAIN each last two cycles, tracked by phase.
    always_comb begin
        state_d = state_q;
        phase_d = 1'b0;
        cnt_d   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (found) state_d = S_GUARD;
            end
            S_GUARD: begin
                if (phase_q) state_d = S_WAIT_ACK;
                else         phase_d = 1'b1;
            end
            S_WAIT_ACK: begin
                if (bus.ACK) begin
                    state_d = S_DRAIN;
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (phase_q) state_d = S_IDLE;
                else         phase_d = 1'b1;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        done_d  = '0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        gid_d   = gid_q;
        ptr_d   = ptr_q;
        fault_d = fault_q;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    gid_d   = pick;
                    rw_d    = bus.REQ_RW[pick];
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    ptr_d   = (pick == IW'(NREQ - 1)) ? '0 : pick + 1'b1;
                end
            end
            S_WAIT_ACK: begin
                if (bus.ACK) begin
                    done_d[gid_q] = 1'b1;
                    rdata_d       = rw_q ? 32'h0 : bus.OUT_DATA;
                    rw_d          = 1'b0;
                end else if (timeout_hit) begin
                    done_d[gid_q] = 1'b1;
                    err_d         = 1'b1;
                    rdata_d       = 32'h0;
                    rw_d          = 1'b0;
                    fault_d       = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESETn) begin
            ptr_q   <= '0;
            gid_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= (state_d != S_IDLE);
            fault_q <= fault_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.DONE     = done_q;
    assign bus.RDATA    = rdata_q;
    assign bus.ERR      = err_q;
    assign bus.GRANT_ID = gid_q;
    assign bus.BUSY     = busy_q;
    assign bus.FAULT    = fault_q;
    assign bus.RW       = rw_q;
    assign bus.ADDRESS  = addr_q;
    assign bus.IN_DATA  = wdata_q;
endmodule

// File: tb/tb_ram_access_arbiter.sv
// Bench for ram_access_arbiter: free-running ram model, timestamp model,
// per-cycle compare plus directed literal checks.
module tb_ram_access_arbiter;
    localparam int NREQ = 4;
    localparam int TMO  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ram_access_arbiter_if #(.NREQ(NREQ)) bus ();

    ram_access_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TMO)
    ) dut (
        .ACLK    (clk),
        .ARESETn (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // ram_access stand-in: re-executes every cycle, answers two cycles later.
    logic [31:0] mem [logic [31:0]];
    int          ack_mode     = 0;
    int          ack_force_at = -1;
    logic        p0_rw = 1'b0, p1_rw = 1'b0;
    logic [31:0] p0_a = '0, p1_a = '0, p0_d = '0, p1_d = '0;

    initial begin
        bus.ACK      = 1'b0;
        bus.OUT_DATA = '0;
    end

    always @(negedge clk) begin : ram_mdl
        logic a;
        a = (ack_mode == 0) || (cyc == ack_force_at);
        bus.ACK      = a;
        bus.OUT_DATA = mem.exists(p1_a) ? mem[p1_a] : 32'h0;
        if (a && p1_rw) mem[p1_a] = p1_d;
        p1_rw = p0_rw;
        p1_a  = p0_a;
        p1_d  = p0_d;
        p0_rw = bus.RW;
        p0_a  = bus.ADDRESS;
        p0_d  = bus.IN_DATA;
    end

    // Expected outputs from transaction timestamps.
    logic [NREQ-1:0] e_done;
    logic            e_err, e_busy, e_fault, e_rw;
    logic [1:0]      e_gid;
    logic [31:0]     e_addr, e_in, e_rdata;
    bit              m_valid  = 1'b0;
    bit              m_active = 1'b0;
    bit              m_fault  = 1'b0;
    int              m_g, m_free, m_ptr, m_id;

    always @(posedge clk) begin : model
        bit f;
        e_done = '0;
        e_err  = 1'b0;
        if (rst) begin
            m_valid  = 1'b1;
            m_active = 1'b0;
            m_fault  = 1'b0;
            m_ptr    = 0;
            m_free   = cyc + 1;
            e_busy   = 1'b0;
            e_fault  = 1'b0;
            e_rw     = 1'b0;
            e_gid    = '0;
            e_addr   = '0;
            e_in     = '0;
            e_rdata  = '0;
        end else if (m_valid) begin
            if (m_fault) begin
            end else if (m_active) begin
                if (cyc >= m_g + 3) begin
                    if (bus.ACK) begin
                        e_done[m_id] = 1'b1;
                        e_rdata  = e_rw ? 32'h0 : bus.OUT_DATA;
                        e_rw     = 1'b0;
                        m_active = 1'b0;
                        m_free   = cyc + 3;
                    end else if (cyc - (m_g + 3) == TMO) begin
                        e_done[m_id] = 1'b1;
                        e_err    = 1'b1;
                        e_rdata  = 32'h0;
                        e_rw     = 1'b0;
                        m_active = 1'b0;
                        m_fault  = 1'b1;
                    end
                end
            end else if (cyc >= m_free && bus.REQ != '0) begin
                f = 1'b0;
                for (int k = 0; k < NREQ; k++) begin
                    if (!f && bus.REQ[(m_ptr + k) % NREQ]) begin
                        f    = 1'b1;
                        m_id = (m_ptr + k) % NREQ;
                    end
                end
                m_g      = cyc;
                m_active = 1'b1;
                m_ptr    = (m_id + 1) % NREQ;
                e_gid    = 2'(m_id);
                e_rw     = bus.REQ_RW[m_id];
                e_addr   = bus.REQ_ADDRESS[32*m_id +: 32];
                e_in     = bus.REQ_WDATA[32*m_id +: 32];
            end
            e_fault = m_fault;
            e_busy  = m_fault || m_active || (cyc + 1 < m_free);
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("done", 32'(bus.DONE), 32'(e_done));
            chk("err", 32'(bus.ERR), 32'(e_err));
            chk("busy", 32'(bus.BUSY), 32'(e_busy));
            chk("fault", 32'(bus.FAULT), 32'(e_fault));
            chk("gid", 32'(bus.GRANT_ID), 32'(e_gid));
            chk("rw", 32'(bus.RW), 32'(e_rw));
            chk("addr", bus.ADDRESS, e_addr);
            chk("in_data", bus.IN_DATA, e_in);
            if (e_done != '0) chk("rdata", bus.RDATA, e_rdata);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.BUSY !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.BUSY !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL wait_idle: BUSY still high after %0d cycles", n);
        end
    endtask

    task automatic wait_done(input int limit, output int at,
                             output logic [NREQ-1:0] d);
        int n = 0;
        at = -1;
        d  = '0;
        while (at < 0 && n < limit) begin
            @(negedge clk);
            n++;
            if (bus.DONE != '0) begin
                at = cyc;
                d  = bus.DONE;
            end
        end
        if (at < 0) begin
            checks++;
            failures++;
            $display("FAIL wait_done: no DONE within %0d cycles", limit);
        end
    endtask

    task automatic set_req(input int i, input logic rw,
                           input logic [31:0] a, input logic [31:0] d);
        bus.REQ_RW[i]              = rw;
        bus.REQ_ADDRESS[32*i +: 32] = a;
        bus.REQ_WDATA[32*i +: 32]   = d;
        bus.REQ[i]                 = 1'b1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int rr_seq [9] = '{0, 1, 2, 3, 0, 2, 3, 0, 2};

    initial begin
        int t, at, prev, n_done;
        logic [NREQ-1:0] d;

        bus.REQ         = '0;
        bus.REQ_RW      = '0;
        bus.REQ_ADDRESS = '0;
        bus.REQ_WDATA   = '0;
        mem[32'h10]     = 32'hCAFEF00D;

        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        chk("rst_busy", 32'(bus.BUSY), 0);
        chk("rst_gid", 32'(bus.GRANT_ID), 0);
        chk("rst_rw", 32'(bus.RW), 0);
        chk("rst_addr", bus.ADDRESS, 0);
        chk("rst_fault", 32'(bus.FAULT), 0);
        chk("rst_done", 32'(bus.DONE), 0);

        t = cyc;
        set_req(1, 1'b0, 32'h10, 32'h0);
        wait_done(20, at, d);
        chk("hit_lat", at - t, 4);
        chk("hit_who", 32'(d), 32'h2);
        chk("hit_rdata", bus.RDATA, 32'hCAFEF00D);
        chk("hit_err", 32'(bus.ERR), 0);
        bus.REQ[1] = 1'b0;
        wait_idle();

        t = cyc;
        set_req(0, 1'b1, 32'h20, 32'h12345678);
        wait_done(20, at, d);
        chk("wr_lat", at - t, 4);
        chk("wr_who", 32'(d), 32'h1);
        chk("wr_rdata", bus.RDATA, 0);
        prev = at;
        bus.REQ_RW[0] = 1'b0;
        wait_done(20, at, d);
        chk("rd_who", 32'(d), 32'h1);
        chk("rd_back", bus.RDATA, 32'h12345678);
        chk("rd_gap", at - prev, 6);
        bus.REQ[0] = 1'b0;
        wait_idle();

        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        set_req(0, 1'b0, 32'h30, 32'h0);
        set_req(2, 1'b0, 32'h34, 32'h0);
        wait_done(20, at, d);
        chk("ct1_who", 32'(d), 32'h1);
        chk("ct1_gid", 32'(bus.GRANT_ID), 0);
        bus.REQ[0] = 1'b0;
        wait_done(20, at, d);
        chk("ct2_who", 32'(d), 32'h4);
        chk("ct2_gid", 32'(bus.GRANT_ID), 2);
        bus.REQ[2] = 1'b0;
        wait_idle();

        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 1'b0, 32'h100 + 32'(4 * i), 32'h0);
        end
        for (int k = 0; k < 9; k++) begin
            wait_done(20, at, d);
            chk("rr_gid", 32'(bus.GRANT_ID), rr_seq[k]);
            chk("rr_who", 32'(d), 32'(1) << rr_seq[k]);
            if (k == 4) bus.REQ[1] = 1'b0;
        end
        bus.REQ = '0;
        wait_idle();

        ack_mode = 1;
        set_req(3, 1'b1, 32'h50, 32'hDEADBEEF);
        tick(5);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_busy", 32'(bus.BUSY), 0);
        chk("mid_rw", 32'(bus.RW), 0);
        chk("mid_addr", bus.ADDRESS, 0);
        chk("mid_in", bus.IN_DATA, 0);
        chk("mid_gid", 32'(bus.GRANT_ID), 0);
        chk("mid_done", 32'(bus.DONE), 0);
        ack_mode = 0;
        set_req(0, 1'b0, 32'h10, 32'h0);
        wait_done(20, at, d);
        chk("post_rst_who", 32'(d), 32'h1);
        chk("post_rst_rdata", bus.RDATA, 32'hCAFEF00D);
        bus.REQ = '0;
        wait_idle();

        ack_mode     = 1;
        t            = cyc;
        ack_force_at = t + 3 + TMO;
        set_req(1, 1'b0, 32'h10, 32'h0);
        wait_done(30, at, d);
        chk("edge_lat", at - t, 4 + TMO);
        chk("edge_err", 32'(bus.ERR), 0);
        chk("edge_rdata", bus.RDATA, 32'hCAFEF00D);
        chk("edge_fault", 32'(bus.FAULT), 0);
        bus.REQ      = '0;
        ack_force_at = -1;
        wait_idle();

        t = cyc;
        set_req(2, 1'b0, 32'h10, 32'h0);
        wait_done(30, at, d);
        chk("tmo_lat", at - t, 4 + TMO);
        chk("tmo_who", 32'(d), 32'h4);
        chk("tmo_err", 32'(bus.ERR), 1);
        chk("tmo_rdata", bus.RDATA, 0);
        bus.REQ  = '0;
        ack_mode = 0;
        tick(1);
        chk("tmo_fault", 32'(bus.FAULT), 1);
        set_req(0, 1'b0, 32'h10, 32'h0);
        n_done = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.DONE != '0) n_done++;
        end
        chk("flt_no_done", n_done, 0);
        chk("flt_busy", 32'(bus.BUSY), 1);
        bus.REQ = '0;

        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("clr_fault", 32'(bus.FAULT), 0);
        chk("clr_busy", 32'(bus.BUSY), 0);
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
